// File: rtl/fetch_stream_unit.sv
// Instruction-fetch front end: requests 64-byte lines, stores their beats in a
// circular byte buffer and presents a 15-byte decode window with its RIP.
module fetch_stream_unit #(
    parameter int BUF_BYTES  = 128,
    parameter int LINE_BYTES = 64,
    parameter int WIN_BYTES  = 15
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [63:0]            entry,
    input  logic                   redirect_valid,
    input  logic [63:0]            redirect_rip,
    output logic                   reqcyc,
    input  logic                   reqack,
    output logic [63:0]            req,
    output logic [12:0]            reqtag,
    input  logic                   respcyc,
    output logic                   respack,
    input  logic [63:0]            resp,
    output logic [8*WIN_BYTES-1:0] win_bytes,
    output logic [7:0]             win_avail,
    output logic [63:0]            win_rip,
    input  logic [3:0]             consume
);
    localparam int PW    = $clog2(BUF_BYTES);
    localparam int LW    = $clog2(LINE_BYTES);
    localparam int BCW   = LW - 3;
    localparam int BEATS = LINE_BYTES / 8;
    localparam logic [12:0] TAG_READ_MEM = {1'b1, 4'b0001, 8'h00};

    typedef enum logic [1:0] {IDLE, REQ, RESP, DRAIN} state_t;

    state_t          state_q, state_d;
    logic            reqcyc_q, reqcyc_d;
    logic [63:0]     req_q, req_d;
    logic [12:0]     reqtag_q, reqtag_d;
    logic [7:0]      occ_q, occ_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [63:0]     fetch_line_q, fetch_line_d;
    logic [63:0]     win_rip_q, win_rip_d;
    logic [LW-1:0]   skip_q, skip_d;
    logic [BCW-1:0]  beat_cnt_q, beat_cnt_d;
    logic [7:0]      mem_q [BUF_BYTES];

    logic            wr_en;
    logic [7:0]      wr_bytes;
    logic [PW-1:0]   rd_adv;
    logic [3:0]      cons_eff;
    logic [8:0]      occ_wide;
    logic            beat_keep;

    assign beat_keep = ({1'b0, beat_cnt_q, 3'b000} + (LW+1)'(8)) > {1'b0, skip_q};
    assign cons_eff  = redirect_valid ? 4'd0 : consume;
    assign occ_wide  = {1'b0, occ_q} + {1'b0, wr_bytes} - {5'd0, cons_eff};

    always_comb begin
        state_d      = state_q;
        reqcyc_d     = reqcyc_q;
        req_d        = req_q;
        reqtag_d     = reqtag_q;
        fetch_line_d = fetch_line_q;
        skip_d       = skip_q;
        beat_cnt_d   = beat_cnt_q;
        wr_en        = 1'b0;
        wr_bytes     = 8'd0;
        rd_adv       = '0;
        case (state_q)
            IDLE: begin
                if (!redirect_valid && occ_q <= 8'(BUF_BYTES - LINE_BYTES)) begin
                    reqcyc_d = 1'b1;
                    req_d    = fetch_line_q;
                    reqtag_d = TAG_READ_MEM;
                    state_d  = REQ;
                end
            end
            REQ: begin
                if (reqack) begin
                    reqcyc_d   = 1'b0;
                    beat_cnt_d = '0;
                    state_d    = redirect_valid ? DRAIN : RESP;
                end else if (redirect_valid) begin
                    state_d = DRAIN;
                end
            end
            RESP: begin
                if (respcyc) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (beat_keep && !redirect_valid) begin
                        wr_en = 1'b1;
                        // The first kept beat may start mid-beat; skip its leading bytes.
                        if (beat_cnt_q == skip_q[LW-1:3]) begin
                            wr_bytes = 8'd8 - {5'd0, skip_q[2:0]};
                            rd_adv   = PW'(skip_q[2:0]);
                        end else begin
                            wr_bytes = 8'd8;
                        end
                    end
                    if (beat_cnt_q == BCW'(BEATS - 1)) begin
                        skip_d       = '0;
                        fetch_line_d = fetch_line_q + 64'(LINE_BYTES);
                        state_d      = IDLE;
                    end else if (redirect_valid) begin
                        state_d = DRAIN;
                    end
                end else if (redirect_valid) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (reqcyc_q) begin
                    if (reqack) begin
                        reqcyc_d   = 1'b0;
                        beat_cnt_d = '0;
                    end
                end else if (respcyc) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (beat_cnt_q == BCW'(BEATS - 1)) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        wr_ptr_d  = wr_en ? wr_ptr_q + PW'(8) : wr_ptr_q;
        rd_ptr_d  = rd_ptr_q + rd_adv + PW'(cons_eff);
        occ_d     = occ_wide[7:0];
        win_rip_d = win_rip_q + 64'(cons_eff);

        if (redirect_valid) begin
            occ_d        = 8'd0;
            rd_ptr_d     = '0;
            wr_ptr_d     = '0;
            win_rip_d    = redirect_rip;
            fetch_line_d = redirect_rip & ~64'(LINE_BYTES - 1);
            skip_d       = redirect_rip[LW-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            reqcyc_q     <= 1'b0;
            req_q        <= 64'd0;
            reqtag_q     <= 13'd0;
            occ_q        <= 8'd0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            fetch_line_q <= entry & ~64'(LINE_BYTES - 1);
            win_rip_q    <= entry;
            skip_q       <= entry[LW-1:0];
            beat_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            reqcyc_q     <= reqcyc_d;
            req_q        <= req_d;
            reqtag_q     <= reqtag_d;
            occ_q        <= occ_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            fetch_line_q <= fetch_line_d;
            win_rip_q    <= win_rip_d;
            skip_q       <= skip_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

    // Buffer storage carries no reset; occupancy alone says what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int k = 0; k < 8; k++) begin
                mem_q[wr_ptr_q + PW'(k)] <= resp[8*k +: 8];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < WIN_BYTES; i++) begin
            win_bytes[8*i +: 8] = mem_q[rd_ptr_q + PW'(i)];
        end
    end

    assign reqcyc    = reqcyc_q;
    assign req       = req_q;
    assign reqtag    = reqtag_q;
    assign respack   = respcyc;
    assign win_avail = occ_q;
    assign win_rip   = win_rip_q;

    occ_bounds_a: assert property (@(posedge clk) disable iff (reset)
        redirect_valid || occ_wide <= 9'(BUF_BYTES));
endmodule

// File: tb/tb_fetch_stream_unit.sv
// Directed bench for fetch_stream_unit with a simple Sysbus line responder
// whose memory returns the low byte of each address.
module tb_fetch_stream_unit;
    logic         clk;
    logic         reset;
    logic [63:0]  entry;
    logic         redirect_valid;
    logic [63:0]  redirect_rip;
    logic         reqcyc;
    logic         reqack;
    logic [63:0]  req;
    logic [12:0]  reqtag;
    logic         respcyc;
    logic         respack;
    logic [63:0]  resp;
    logic [119:0] win_bytes;
    logic [7:0]   win_avail;
    logic [63:0]  win_rip;
    logic [3:0]   consume;

    fetch_stream_unit dut (
        .clk(clk), .reset(reset), .entry(entry),
        .redirect_valid(redirect_valid), .redirect_rip(redirect_rip),
        .reqcyc(reqcyc), .reqack(reqack), .req(req), .reqtag(reqtag),
        .respcyc(respcyc), .respack(respack), .resp(resp),
        .win_bytes(win_bytes), .win_avail(win_avail), .win_rip(win_rip),
        .consume(consume)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          checks = 0;
    int          passes = 0;
    logic        resp_en;
    int          beats_left;
    int          beats_total;
    int          nreq;
    logic [63:0] cur_addr;
    logic [63:0] last_req;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [63:0] beat_data(input logic [63:0] a);
        logic [63:0] d;
        for (int k = 0; k < 8; k++) d[8*k +: 8] = 8'(a + 64'(k));
        return d;
    endfunction

    function automatic logic [7:0] wbyte(input int i);
        return win_bytes[8*i +: 8];
    endfunction

    // Bus responder: acks a pending request, then streams its 8 beats.
    initial begin
        reqack = 1'b0; respcyc = 1'b0; resp = '0;
        beats_left = 0; beats_total = 0; nreq = 0;
        cur_addr = '0; last_req = '0;
        forever begin
            @(negedge clk);
            reqack  = 1'b0;
            respcyc = 1'b0;
            if (reset) begin
                beats_left = 0; beats_total = 0; nreq = 0;
            end else if (beats_left > 0) begin
                if (resp_en) begin
                    respcyc = 1'b1;
                    resp = beat_data(cur_addr + 64'(8 * (8 - beats_left)));
                    beats_left--;
                    beats_total++;
                end
            end else if (reqcyc) begin
                reqack = 1'b1;
                cur_addr = req;
                last_req = req;
                nreq++;
                beats_left = 8;
            end
        end
    end

    task automatic do_reset(input logic [63:0] e);
        @(negedge clk);
        reset = 1'b1; entry = e; redirect_valid = 1'b0; redirect_rip = '0;
        consume = 4'd0; resp_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_reqcyc", reqcyc, 0);
        chk("rst_req", req, 0);
        chk("rst_avail", win_avail, 0);
        chk("rst_rip", win_rip, e);
        reset = 1'b0;
    endtask

    task automatic wait_beats(input int n);
        int t = 0;
        while (beats_total < n && t < 500) begin
            @(posedge clk);
            t++;
        end
        #1;
        chk("beat_wait_timeout", 64'(t < 500), 1);
    endtask

    typedef struct {
        logic [63:0] entry;
        logic [63:0] exp_req;
        logic [7:0]  exp_avail;
        logic [7:0]  exp_b0;
        logic [7:0]  exp_b14;
        bit          chk14;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int drained, ack_bad, avail_bad, t;

        tbl[0] = '{64'h1000, 64'h1000, 8'd64, 8'h00, 8'h0E, 1'b1};
        tbl[1] = '{64'h1013, 64'h1000, 8'd45, 8'h13, 8'h21, 1'b1};
        tbl[2] = '{64'h2007, 64'h2000, 8'd57, 8'h07, 8'h15, 1'b1};
        tbl[3] = '{64'h3038, 64'h3000, 8'd8,  8'h38, 8'h00, 1'b0};
        tbl[4] = '{64'h4021, 64'h4000, 8'd31, 8'h21, 8'h2F, 1'b1};

        reset = 1'b1; entry = '0; redirect_valid = 1'b0; redirect_rip = '0;
        consume = 4'd0; resp_en = 1'b1;

        // First line after reset for several entry alignments.
        for (int v = 0; v < 5; v++) begin
            do_reset(tbl[v].entry);
            @(posedge clk); #1;
            chk("first_reqcyc", reqcyc, 1);
            chk("first_req", req, tbl[v].exp_req);
            chk("first_tag", reqtag, 13'h1100);
            wait_beats(8);
            chk("line_avail", win_avail, tbl[v].exp_avail);
            chk("line_b0", wbyte(0), tbl[v].exp_b0);
            if (tbl[v].chk14) chk("line_b14", wbyte(14), tbl[v].exp_b14);
            chk("line_rip", win_rip, tbl[v].entry);
        end

        // Fill to capacity, stall, then drain so the read pointer wraps.
        do_reset(64'h1000);
        wait_beats(16);
        repeat (10) @(posedge clk);
        #1;
        chk("full_avail", win_avail, 128);
        chk("full_stall_reqcyc", reqcyc, 0);
        chk("full_nreq", 64'(nreq), 2);
        resp_en = 1'b0;
        for (int c = 0; c < 8; c++) begin
            consume = 4'd15;
            @(posedge clk); #1;
        end
        consume = 4'd0;
        chk("drain_avail", win_avail, 8);
        chk("drain_rip", win_rip, 64'h1078);
        chk("third_nreq", 64'(nreq), 3);
        chk("third_req", last_req, 64'h1080);
        resp_en = 1'b1;
        wait_beats(24);
        chk("wrap_avail", win_avail, 72);
        for (int i = 0; i < 15; i++) chk("wrap_byte", wbyte(i), 64'(8'h78 + 8'(i)));

        // Redirect arriving with beat 3 of the first line.
        do_reset(64'h1000);
        wait_beats(3);
        redirect_valid = 1'b1;
        redirect_rip = 64'h2040;
        drained = 0; ack_bad = 0; avail_bad = 0; t = 0;
        while (drained < 5 && t < 40) begin
            @(posedge clk); #1;
            redirect_valid = 1'b0;
            if (respcyc) begin
                drained++;
                if (!respack) ack_bad++;
            end
            if (win_avail != 8'd0) avail_bad++;
            t++;
        end
        chk("drain_beats", 64'(drained), 5);
        chk("drain_respack", 64'(ack_bad), 0);
        chk("drain_zero_avail", 64'(avail_bad), 0);
        chk("redir_rip", win_rip, 64'h2040);
        t = 0;
        while (nreq < 2 && t < 40) begin
            @(posedge clk); t++;
        end
        #1;
        chk("redir_req", last_req, 64'h2040);
        wait_beats(16);
        chk("redir_avail", win_avail, 64);
        chk("redir_b0", wbyte(0), 8'h40);

        // Beat and consume in the same cycle at occupancy 20.
        do_reset(64'h100C);
        wait_beats(4);
        resp_en = 1'b0;
        chk("occ20_avail", win_avail, 20);
        chk("occ20_b0", wbyte(0), 8'h0C);
        consume = 4'd7;
        resp_en = 1'b1;
        @(posedge clk); #1;
        consume = 4'd0;
        chk("wc_avail", win_avail, 21);
        chk("wc_rip", win_rip, 64'h1013);
        chk("wc_b0", wbyte(0), 8'h13);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end
endmodule

// File: doc/fetch_stream_unit.md
Name: fetch_stream_unit

Overview:
- Instruction-fetch front end that sits directly upstream of the decoder.
- Issues 64-byte line reads on the Sysbus and captures the 8-byte response beats into a 128-byte circular byte buffer.
- Presents a 15-byte decode window, together with its RIP, to the decoder, which consumes 0..15 bytes per cycle.
- Supports a redirect (branch/entry change) that flushes the buffer and any in-flight line.

Parameters:
- BUF_BYTES, 128, circular buffer capacity in bytes; must be a power of 2 and at least 2*LINE_BYTES.
- LINE_BYTES, 64, bytes per bus read request (8 beats).
- WIN_BYTES, 15, decode window width in bytes (maximum x86 instruction length).

Ports:
- clk  in  1  core clock (same clock as bus.clk).
- reset  in  1  asynchronous, active-high reset.
- entry  in  64  initial RIP; must be stable while reset is high.
- redirect_valid  in  1  flush the buffer and restart fetch at redirect_rip.
- redirect_rip  in  64  new fetch RIP.
- reqcyc  out  1  bus request valid.
- reqack  in  1  bus accepted the request.
- req  out  64  line address, always LINE_BYTES aligned.
- reqtag  out  13  {READ, MEMORY, 8'b0} from the Sysbus constants.
- respcyc  in  1  response beat valid.
- respack  out  1  beat accepted.
- resp  in  64  response beat data; the byte at the lowest address is resp[7:0].
- win_bytes  out  120  decode window; byte i is at [8i+7:8i].
- win_avail  out  8  valid bytes currently buffered (0..BUF_BYTES).
- win_rip  out  64  RIP of window byte 0.
- consume  in  4  bytes the decoder retires this cycle; must be ≤ min(win_avail, 15).

Behaviour:
- Reset (asynchronous):
  - reqcyc=0, req=0, reqtag=0, occupancy=0, rd_ptr=wr_ptr=0, state=IDLE.
  - fetch_line = entry & ~63; win_rip = entry; skip_bytes = entry[5:0].
- respack = respcyc (combinational). The unit always accepts beats, because space is reserved before a request is issued.
- State machine:
  - IDLE: if occupancy ≤ BUF_BYTES-LINE_BYTES and redirect_valid=0, register reqcyc=1, req=fetch_line, reqtag, then go to REQ (reqcyc is visible the cycle after the decision).
  - REQ: hold reqcyc, req and reqtag stable until reqack is sampled high. Then drop reqcyc, clear beat_cnt, go to RESP.
  - RESP: each respcyc increments beat_cnt (3 bits).
    - Beats whose line offset (beat_cnt*8) + 8 ≤ skip_bytes are discarded.
    - Every other beat is written at wr_ptr, and wr_ptr advances by 8 modulo BUF_BYTES.
    - On the first kept beat, rd_ptr additionally advances by skip_bytes[2:0] and occupancy adds 8-skip_bytes[2:0].
    - On the 8th beat: skip_bytes=0, fetch_line += 64, go to IDLE.
  - DRAIN: entered when redirect_valid occurs in REQ or RESP. Keep holding the request until reqack if still in REQ. Accept and discard all remaining beats of that line (8 total counted), then go to IDLE.
- Redirect, in any state:
  - Same cycle: occupancy=0, rd_ptr=wr_ptr=0, win_rip=redirect_rip, fetch_line=redirect_rip & ~63, skip_bytes=redirect_rip[5:0].
  - Redirect overrides any consume in the same cycle. A redirect during DRAIN restarts the flush parameters but does not extend the drain.
- Occupancy arithmetic: next = occ + written_bytes - consume, 8-bit, never above BUF_BYTES and never below 0. A violation triggers an assertion failure.
  - A simultaneous write and consume apply in the same cycle.
  - rd_ptr += consume modulo BUF_BYTES; win_rip += consume with 64-bit wrap.
- Window: win_bytes[i] = buf[(rd_ptr+i) mod BUF_BYTES], i=0..14, wrapping across the buffer end. Bytes at index ≥ win_avail are don't-care.
- Outputs are combinational from registered state. Latency: a byte written by a beat at cycle N is visible in the window at cycle N+1.
- No new request is issued while the buffer lacks 64 free bytes. Fetch stalls until the decoder consumes.

Test Plan:
- Reset with entry=0x1000, memory model returns bytes 00..3F → req=0x1000 one cycle after reset release; after 8 beats, win_avail=64, win_bytes byte0=0x00, byte14=0x0E, win_rip=0x1000.
- entry=0x1013 → beats 0,1 discarded, beat 2 kept; win_rip=0x1013, window byte0 = memory byte 0x13, win_avail=45.
- Decoder never consumes → second line fetched (win_avail=128), then reqcyc stays 0. Consume 15 per cycle → third request issues once win_avail ≤ 64.
- rd_ptr=120 with consume=0 → window bytes 8..14 are taken from buffer offsets 0..6 (wrap-around), matching memory at win_rip+8..14.
- redirect_valid to 0x2040 during beat 3 of a line → remaining 5 beats accepted with respack=1 but not written, win_avail=0 throughout, next req=0x2040.
- Beat arrival and consume=7 in the same cycle with occupancy 20 → occupancy 21, win_rip advances by 7.
